itch_decoder_arbiter: RTL and testbench

- Merges the completion outputs of the parallel speculative ITCH decoders (add, cancel, delete, replace, …) into one ordered message stream.
- Each decoder pulses its internal_valid for one cycle with its fields. This block selects one winner per cycle and buffers it in a small FIFO.
- Drains the FIFO to the downstream order-book stage over a valid/ready handshake.
- Reports collisions, overflow drops and decoder packet_invalid events.

---
 rtl/itch_arb_pkg.sv | 31 +++
 rtl/itch_arb_fifo.sv | 77 +++++++
 rtl/itch_decoder_arbiter.sv | 150 +++++++++++++++
 tb/tb_itch_decoder_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itch_arb_pkg.sv
// itch_arb_pkg: shared entry type, ITCH message type codes and the saturating
// counter helper used by the decoder arbiter and its output FIFO.
// The entry payload field is DEFAULT_PAYLOAD_W bits wide; narrower source
// payloads are zero-extended into it, so PAYLOAD_W must not exceed it.
package itch_arb_pkg;

  localparam int DEFAULT_PAYLOAD_W = 160;

  localparam logic [7:0] ITCH_ADD     = 8'h41;  // 'A'
  localparam logic [7:0] ITCH_CANCEL  = 8'h58;  // 'X'
  localparam logic [7:0] ITCH_DELETE  = 8'h44;  // 'D'
  localparam logic [7:0] ITCH_REPLACE = 8'h55;  // 'U'
  localparam logic [7:0] ITCH_EXECUTE = 8'h45;  // 'E'

  typedef struct packed {
    logic [7:0]                   msg_type;
    logic [2:0]                   src_id;
    logic [DEFAULT_PAYLOAD_W-1:0] payload;
  } msg_entry_t;

  // Add inc to cur, clamping at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cur,
                                          input logic [31:0] inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/itch_arb_fifo.sv
// itch_arb_fifo: small synchronous FIFO of msg_entry_t with a registered head.
// The head register keeps its last value when the FIFO drains or is flushed,
// so downstream data only changes on a pop or a push into an empty buffer.
// Flush has priority over push and pop. DEPTH must be a power of 2.
module itch_arb_fifo
  import itch_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  msg_entry_t push_data,
  input  logic       pop,
  input  logic       flush,
  output logic       full,
  output logic       empty,
  output msg_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  msg_entry_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] next_rd;
  logic [CW-1:0] count;
  logic [CW-1:0] next_count;
  logic          do_push;
  logic          do_pop;
  msg_entry_t    head_q;
  msg_entry_t    head_next;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = head_q;

  // Resolve the accepted operations and what the head register shows next
  always_comb begin
    do_pop     = pop && !empty && !flush;
    do_push    = push && !flush && (!full || do_pop);
    next_rd    = rd_ptr + AW'(do_pop);
    next_count = count + CW'(do_push) - CW'(do_pop);
    head_next  = head_q;
    if (!flush && (next_count != '0)) begin
      if (do_push && (wr_ptr == next_rd)) head_next = push_data;
      else                                head_next = mem[next_rd];
    end
  end

  // Entry storage; stale slots are never exposed, so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and head register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head_q <= head_next;
    end else begin
      rd_ptr <= next_rd;
      wr_ptr <= wr_ptr + AW'(do_push);
      count  <= next_count;
      head_q <= head_next;
    end
  end

endmodule

// File: rtl/itch_decoder_arbiter.sv
// itch_decoder_arbiter: merges the one-cycle completion pulses of the parallel
// ITCH decoders into one ordered stream. One winner per cycle is buffered in
// itch_arb_fifo and drained over a valid/ready handshake; losers and entries
// refused by a full buffer are counted as drops.
// Optional feature macro: ITCH_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration (search starts at rr_ptr); when undefined the lowest
// qualified index wins and no rr_ptr state exists.
module itch_decoder_arbiter
  import itch_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int PAYLOAD_W  = 160,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC-1:0]             src_invalid,
  input  logic [NUM_SRC*8-1:0]           src_type,
  input  logic [NUM_SRC*PAYLOAD_W-1:0]   src_payload,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [7:0]                     out_type,
  output logic [2:0]                     out_src_id,
  output logic [PAYLOAD_W-1:0]           out_payload,
  output logic                           packet_invalid,
  output logic                           collision,
  output logic                           overflow,
  output logic [CNT_W-1:0]               drop_count,
  output logic [CNT_W-1:0]               collision_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_SRC-1:0] qual;
  logic [3:0]         qual_cnt;
  logic               any_qual;
  logic               multi_qual;
  logic [2:0]         win_id;
  msg_entry_t         win_entry;
  msg_entry_t         head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               push;
  logic               overflow_drop;
  logic [3:0]         drop_inc;

  // Mask invalidated requests and count the decoders completing this cycle
  always_comb begin
    qual     = src_valid & ~src_invalid;
    qual_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) qual_cnt = qual_cnt + {3'b000, qual[i]};
  end

  assign any_qual   = |qual;
  assign multi_qual = (qual_cnt > 4'd1);

`ifdef ITCH_ARB_ROUND_ROBIN_EN
  logic [2:0]         rr_ptr;
  logic [NUM_SRC-1:0] rot;
  logic [3:0]         rr_off;
  logic [3:0]         rr_sum;

  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, rotate back
  always_comb begin
    rot    = NUM_SRC'({qual, qual} >> rr_ptr);
    rr_off = '0;
    for (int j = NUM_SRC - 1; j >= 0; j--) if (rot[j]) rr_off = 4'(j);
    rr_sum = {1'b0, rr_ptr} + rr_off;
    if (rr_sum >= 4'(NUM_SRC)) rr_sum = rr_sum - 4'(NUM_SRC);
    win_id = 3'(rr_sum);
  end

  // Move the search start just past each granted source; hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (any_qual) begin
      if (win_id == 3'(NUM_SRC - 1)) rr_ptr <= '0;
      else                           rr_ptr <= win_id + 3'd1;
    end
  end
`else
  // Fixed priority: scan downwards so the lowest requesting index wins
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (qual[i]) win_id = 3'(i);
  end
`endif

  // Gather the winner's fields, zero-extending the payload into the entry
  always_comb begin
    win_entry        = '0;
    win_entry.src_id = win_id;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_id == 3'(i)) begin
        win_entry.msg_type               = src_type[8*i +: 8];
        win_entry.payload[PAYLOAD_W-1:0] = src_payload[PAYLOAD_W*i +: PAYLOAD_W];
      end
    end
  end

  // A full buffer still accepts the winner when the head leaves this cycle;
  // a flushed winner is discarded silently rather than counted as a drop.
  assign pop           = !fifo_empty && out_ready;
  assign push          = any_qual && !flush && (!fifo_full || pop);
  assign overflow_drop = any_qual && !flush && fifo_full && !pop;
  assign drop_inc      = (any_qual ? (qual_cnt - 4'd1) : 4'd0) + {3'b000, overflow_drop};

  itch_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (win_entry),
    .pop       (pop),
    .flush     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign out_valid   = !fifo_empty;
  assign out_type    = head.msg_type;
  assign out_src_id  = head.src_id;
  assign out_payload = head.payload[PAYLOAD_W-1:0];

  // Status pulses, sticky overflow flag and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      packet_invalid  <= 1'b0;
      collision       <= 1'b0;
      overflow        <= 1'b0;
      drop_count      <= '0;
      collision_count <= '0;
    end else begin
      packet_invalid <= |src_invalid;
      collision      <= multi_qual;
      if (overflow_drop) overflow <= 1'b1;
      drop_count <= CNT_W'(sat_inc(32'(drop_count), 32'(drop_inc), 32'(CNT_MAX)));
      if (multi_qual)
        collision_count <= CNT_W'(sat_inc(32'(collision_count), 32'd1, 32'(CNT_MAX)));
    end
  end

endmodule

// File: tb/tb_itch_decoder_arbiter.sv
// tb_itch_decoder_arbiter: scoreboard bench for itch_decoder_arbiter.
// Expected entries are queued when a winner is driven and compared as the
// DUT presents them. Counters use CNT_W=4 so saturation is reachable.
// Follows ITCH_ARB_ROUND_ROBIN_EN for the expected winner.
module tb_itch_decoder_arbiter;
  import itch_arb_pkg::*;

  localparam int NS    = 4;
  localparam int PW    = 160;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef ITCH_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif
  localparam logic [7:0] TYPE_TAB [5] = '{ITCH_ADD, ITCH_CANCEL, ITCH_DELETE,
                                          ITCH_REPLACE, ITCH_EXECUTE};

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     src_valid;
  logic [NS-1:0]     src_invalid;
  logic [NS*8-1:0]   src_type;
  logic [NS*PW-1:0]  src_payload;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_type;
  logic [2:0]        out_src_id;
  logic [PW-1:0]     out_payload;
  logic              packet_invalid;
  logic              collision;
  logic              overflow;
  logic [CW-1:0]     drop_count;
  logic [CW-1:0]     collision_count;

  typedef struct {
    logic [7:0]    t;
    logic [2:0]    id;
    logic [PW-1:0] p;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_drop;
  int   exp_coll;
  int   exp_rr;
  logic exp_ovf;

  itch_decoder_arbiter #(
    .NUM_SRC    (NS),
    .PAYLOAD_W  (PW),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .src_valid       (src_valid),
    .src_invalid     (src_invalid),
    .src_type        (src_type),
    .src_payload     (src_payload),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_type        (out_type),
    .out_src_id      (out_src_id),
    .out_payload     (out_payload),
    .packet_invalid  (packet_invalid),
    .collision       (collision),
    .overflow        (overflow),
    .drop_count      (drop_count),
    .collision_count (collision_count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src_valid   = '0;
    src_invalid = '0;
    src_type    = '0;
    src_payload = '0;
    flush       = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [7:0] ty, input logic [PW-1:0] pl);
    src_valid[i]             = 1'b1;
    src_type[8*i +: 8]       = ty;
    src_payload[PW*i +: PW]  = pl;
  endtask

  task automatic push_exp(input int i, input logic [7:0] ty, input logic [PW-1:0] pl);
    sb.push_back('{t: ty, id: 3'(i), p: pl});
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Expected winner: search from the modelled pointer (always 0 for fixed priority)
  function automatic int exp_winner(input logic [NS-1:0] m);
    for (int k = 0; k < NS; k++) if (m[(exp_rr + k) % NS]) return (exp_rr + k) % NS;
    return -1;
  endfunction

  task automatic note_grant(input int w);
    exp_rr = RR_EN ? (w + 1) % NS : 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    sb.delete();
    exp_drop = 0;
    exp_coll = 0;
    exp_rr   = 0;
    exp_ovf  = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_type !== 8'h00) begin errors++; $display("[TB] FAIL rst_out_type: got %h want 00", out_type); end
    checks++; if (out_src_id !== 3'd0) begin errors++; $display("[TB] FAIL rst_out_src_id: got %0d want 0", out_src_id); end
    checks++; if (out_payload !== '0) begin errors++; $display("[TB] FAIL rst_out_payload: got %h want 0", out_payload); end
    checks++; if (packet_invalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_packet_invalid: got %b want 0", packet_invalid); end
    checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL rst_collision: got %b want 0", collision); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_overflow: got %b want 0", overflow); end
    checks++; if (drop_count !== '0) begin errors++; $display("[TB] FAIL rst_drop_count: got %0d want 0", drop_count); end
    checks++; if (collision_count !== '0) begin errors++; $display("[TB] FAIL rst_collision_count: got %0d want 0", collision_count); end
  endtask

  task automatic test_single();
    exp_t e;
    out_ready = 1'b1;
    set_src(3, ITCH_REPLACE, 160'h0123456789abcdef0123456789abcdef01234567);
    push_exp(3, ITCH_REPLACE, 160'h0123456789abcdef0123456789abcdef01234567);
    note_grant(3);
    tick();
    clear_inputs();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b want 1", out_valid); end
    e = sb.pop_front();
    checks++;
    if (out_type !== e.t || out_src_id !== e.id || out_payload !== e.p) begin
      errors++;
      $display("[TB] FAIL single_entry: got %h/%0d/%h want %h/%0d/%h", out_type, out_src_id, out_payload, e.t, e.id, e.p);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_popped: got %b want 0", out_valid); end
    checks++; if (out_type !== ITCH_REPLACE) begin errors++; $display("[TB] FAIL single_hold: got %h want %h", out_type, ITCH_REPLACE); end
  endtask

  task automatic test_collision();
    exp_t          e;
    int            w;
    logic [7:0]    ty [NS];
    logic [PW-1:0] pl [NS];
    ty[0] = ITCH_ADD;    pl[0] = {5{32'h0A0A0000}};
    ty[1] = ITCH_CANCEL; pl[1] = {5{32'h1B1B1111}};
    ty[2] = ITCH_DELETE; pl[2] = {5{32'h2C2C2222}};
    ty[3] = ITCH_EXECUTE; pl[3] = {5{32'h3D3D3333}};
    out_ready = 1'b1;
    set_src(0, ty[0], pl[0]);
    set_src(2, ty[2], pl[2]);
    w = exp_winner(4'b0101);
    push_exp(w, ty[w], pl[w]);
    note_grant(w);
    exp_coll = sat(exp_coll + 1);
    exp_drop = sat(exp_drop + 1);
    tick();
    clear_inputs();
    checks++; if (collision !== 1'b1) begin errors++; $display("[TB] FAIL coll_pulse: got %b want 1", collision); end
    checks++; if (collision_count !== CW'(exp_coll)) begin errors++; $display("[TB] FAIL coll_count: got %0d want %0d", collision_count, exp_coll); end
    checks++; if (drop_count !== CW'(exp_drop)) begin errors++; $display("[TB] FAIL coll_drop: got %0d want %0d", drop_count, exp_drop); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL coll_valid: got %b want 1", out_valid); end
    e = sb.pop_front();
    checks++;
    if (out_type !== e.t || out_src_id !== e.id || out_payload !== e.p) begin
      errors++;
      $display("[TB] FAIL coll_winner: got %h/%0d want %h/%0d", out_type, out_src_id, e.t, e.id);
    end
    tick();
    checks++; if (collision !== 1'b0) begin errors++; $display("[TB] FAIL coll_once: got %b want 0", collision); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL coll_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    exp_t          e;
    int            n;
    logic [PW-1:0] pl;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pl = {5{32'hA5A50000 + 32'(k)}};
      set_src(1, TYPE_TAB[k], pl);
      note_grant(1);
      if (k < DEPTH) push_exp(1, TYPE_TAB[k], pl);
      else begin
        exp_drop = sat(exp_drop + 1);
        exp_ovf  = 1'b1;
      end
      tick();
      clear_inputs();
    end
    checks++; if (overflow !== exp_ovf) begin errors++; $display("[TB] FAIL bp_overflow: got %b want %b", overflow, exp_ovf); end
    checks++; if (drop_count !== CW'(exp_drop)) begin errors++; $display("[TB] FAIL bp_drop: got %0d want %0d", drop_count, exp_drop); end
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (out_valid !== 1'b1 || out_type !== sb[0].t || out_payload !== sb[0].p) begin
        errors++;
        $display("[TB] FAIL bp_stall%0d: got %b/%h want 1/%h", s, out_valid, out_type, sb[0].t);
      end
      tick();
    end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 16 && out_valid === 1'b1; c++) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL bp_extra: got entry %h/%0d want none", out_type, out_src_id);
      end else begin
        e = sb.pop_front();
        if (out_type !== e.t || out_src_id !== e.id || out_payload !== e.p) begin
          errors++;
          $display("[TB] FAIL bp_entry%0d: got %h/%0d/%h want %h/%0d/%h", n, out_type, out_src_id, out_payload, e.t, e.id, e.p);
        end
      end
      n++;
      tick();
    end
    checks++; if (n != DEPTH) begin errors++; $display("[TB] FAIL bp_count: got %0d want %0d", n, DEPTH); end
  endtask

  task automatic test_full_pop();
    exp_t          e;
    int            n;
    logic [PW-1:0] pl;
    test_reset();
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      pl = {5{32'hC0DE0000 + 32'(k)}};
      set_src(2, TYPE_TAB[k], pl);
      push_exp(2, TYPE_TAB[k], pl);
      note_grant(2);
      tick();
      clear_inputs();
    end
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_type !== e.t || out_payload !== e.p) begin
      errors++;
      $display("[TB] FAIL fp_head: got %b/%h want 1/%h", out_valid, out_type, e.t);
    end
    out_ready = 1'b1;
    set_src(0, ITCH_EXECUTE, {5{32'hFEED0004}});
    push_exp(0, ITCH_EXECUTE, {5{32'hFEED0004}});
    note_grant(0);
    tick();
    clear_inputs();
    out_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fp_overflow: got %b want 0", overflow); end
    checks++; if (drop_count !== CW'(exp_drop)) begin errors++; $display("[TB] FAIL fp_drop: got %0d want %0d", drop_count, exp_drop); end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 16 && out_valid === 1'b1; c++) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL fp_extra: got entry %h/%0d want none", out_type, out_src_id);
      end else begin
        e = sb.pop_front();
        if (out_type !== e.t || out_src_id !== e.id || out_payload !== e.p) begin
          errors++;
          $display("[TB] FAIL fp_entry%0d: got %h/%0d/%h want %h/%0d/%h", n, out_type, out_src_id, out_payload, e.t, e.id, e.p);
        end
      end
      n++;
      tick();
    end
    checks++; if (n != DEPTH) begin errors++; $display("[TB] FAIL fp_occupancy: got %0d want %0d", n, DEPTH); end
  endtask

  task automatic test_invalid();
    out_ready = 1'b1;
    set_src(1, ITCH_CANCEL, {5{32'hBAD00001}});
    src_invalid[1] = 1'b1;
    tick();
    clear_inputs();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL inv_pushed: got %b want 0", out_valid); end
    checks++; if (packet_invalid !== 1'b1) begin errors++; $display("[TB] FAIL inv_pulse: got %b want 1", packet_invalid); end
    checks++; if (drop_count !== CW'(exp_drop)) begin errors++; $display("[TB] FAIL inv_drop: got %0d want %0d", drop_count, exp_drop); end
    tick();
    checks++; if (packet_invalid !== 1'b0) begin errors++; $display("[TB] FAIL inv_once: got %b want 0", packet_invalid); end
  endtask

  task automatic test_flush();
    exp_t          e;
    logic [PW-1:0] pl;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pl = {5{32'hF1F10000 + 32'(k)}};
      set_src(1, TYPE_TAB[k + 1], pl);
      note_grant(1);
      tick();
      clear_inputs();
    end
    flush = 1'b1;
    set_src(2, ITCH_ADD, {5{32'hDEAD0002}});
    note_grant(2);
    tick();
    clear_inputs();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_valid: got %b want 0", out_valid); end
    checks++; if (drop_count !== CW'(exp_drop)) begin errors++; $display("[TB] FAIL fl_drop: got %0d want %0d", drop_count, exp_drop); end
    checks++; if (overflow !== exp_ovf) begin errors++; $display("[TB] FAIL fl_overflow: got %b want %b", overflow, exp_ovf); end
    checks++; if (out_type !== TYPE_TAB[1]) begin errors++; $display("[TB] FAIL fl_hold: got %h want %h", out_type, TYPE_TAB[1]); end
    out_ready = 1'b1;
    set_src(0, ITCH_DELETE, {5{32'h600D0000}});
    push_exp(0, ITCH_DELETE, {5{32'h600D0000}});
    note_grant(0);
    tick();
    clear_inputs();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_type !== e.t || out_src_id !== e.id || out_payload !== e.p) begin
      errors++;
      $display("[TB] FAIL fl_reuse: got %b/%h/%0d want 1/%h/%0d", out_valid, out_type, out_src_id, e.t, e.id);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_reuse_pop: got %b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    int w;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_src(0, ITCH_ADD, {5{32'h5A700000 + 32'(k)}});
      set_src(1, ITCH_CANCEL, {5{32'h5A710000 + 32'(k)}});
      w = exp_winner(4'b0011);
      note_grant(w);
      exp_coll = sat(exp_coll + 1);
      exp_drop = sat(exp_drop + 1);
      tick();
      clear_inputs();
    end
    tick();
    checks++; if (collision_count !== CW'(exp_coll)) begin errors++; $display("[TB] FAIL sat_coll: got %0d want %0d", collision_count, exp_coll); end
    checks++; if (drop_count !== CW'(exp_drop)) begin errors++; $display("[TB] FAIL sat_drop: got %0d want %0d", drop_count, exp_drop); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL sat_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_src(0, ITCH_REPLACE, {5{32'h77770000}});
    set_src(1, ITCH_DELETE, {5{32'h77770001}});
    tick();
    clear_inputs();
    set_src(3, ITCH_EXECUTE, {5{32'h77770003}});
    tick();
    clear_inputs();
    test_reset();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_survivor: got %b want 0", out_valid); end
  endtask

  // Run every scenario in order, then report
  initial begin
    clear_inputs();
    out_ready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_collision();
    test_backpressure();
    test_full_pop();
    test_invalid();
    test_flush();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
